// File: rtl/serial_ctrl_pkg.sv
// Shared definitions for the serial port controller:
// frame state encoding, default field widths and counter sizing.
package serial_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, PORT, LEN, DATA, DONE} state_t;

  localparam int DEF_PORT_W = 2;
  localparam int DEF_LEN_W  = 4;

  // One counter serves both header fields and the payload, so it is sized for the wider field.
  function automatic int cntWidth(input int portW, input int lenW);
    return (portW > lenW) ? portW : lenW;
  endfunction

endpackage

// File: rtl/frame_bit_counter.sv
// Loadable down-counter that tracks the remaining bits of the current frame field.
module frame_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         en,
  input  logic [W-1:0] ldVal,
  output logic         zero
);

  logic [W-1:0] count;

  // Counting stops at zero instead of wrapping; a load always wins over a decrement.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (ld)
      count <= ldVal;
    else if (en && (count != '0))
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/serial_port_controller.sv
// Frame-sequencing controller: decodes start/port/length from serIn and
// steers the payload bits to the addressed port with a registered data/valid pair.
module serial_port_controller
  import serial_ctrl_pkg::*;
#(
  parameter int PORT_W = DEF_PORT_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serIn,
  output logic                 serOut,
  output logic                 outputValid,
  output logic [2**PORT_W-1:0] portEn,
  output logic [PORT_W-1:0]    port,
  output logic                 done,
  output logic                 busy
);

  localparam int CW = cntWidth(PORT_W, LEN_W);
  localparam int NP = 2**PORT_W;

  state_t            state;
  state_t            stateNext;
  logic [PORT_W-1:0] portShift;
  logic [PORT_W-1:0] portFull;
  logic [LEN_W-1:0]  lenReg;
  logic [LEN_W-1:0]  lenFull;
  logic              lenIsZero;
  logic              cntLd;
  logic              cntEn;
  logic              cntZero;
  logic [CW-1:0]     cntVal;

  // Field values including the bit being sampled this cycle, so decisions on the last bit see the whole field.
  assign portFull  = PORT_W'({portShift, serIn});
  assign lenFull   = LEN_W'({lenReg, serIn});
  assign lenIsZero = (lenFull == '0);

  frame_bit_counter #(.W(CW)) u_counter (
    .clk   (clk),
    .rst   (rst),
    .ld    (cntLd),
    .en    (cntEn),
    .ldVal (cntVal),
    .zero  (cntZero)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (serIn) stateNext = PORT;
      PORT: if (cntZero) stateNext = LEN;
      LEN:  if (cntZero) stateNext = lenIsZero ? DONE : DATA;
      DATA: if (cntZero) stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    done   = (state == DONE);
    cntLd  = 1'b0;
    cntEn  = 1'b0;
    cntVal = '0;
    case (state)
      IDLE: begin
        cntLd  = serIn;
        cntVal = CW'(PORT_W - 1);
      end
      PORT: begin
        cntEn  = 1'b1;
        cntLd  = cntZero;
        cntVal = CW'(LEN_W - 1);
      end
      LEN: begin
        cntEn  = 1'b1;
        cntLd  = cntZero && !lenIsZero;
        cntVal = CW'(lenFull - LEN_W'(1));
      end
      DATA: cntEn = 1'b1;
      default: ;
    endcase
  end

  // Port is only published once the field is complete, so it stays stable across the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      serOut      <= 1'b0;
      outputValid <= 1'b0;
      portShift   <= '0;
      port        <= '0;
      lenReg      <= '0;
    end else begin
      serOut      <= (state == DATA) ? serIn : 1'b0;
      outputValid <= (state == DATA);
      if (state == PORT) begin
        portShift <= portFull;
        if (cntZero)
          port <= portFull;
      end
      if (state == LEN)
        lenReg <= lenFull;
    end
  end

  assign portEn = outputValid ? (NP'(1) << port) : '0;

endmodule

// File: tb/tb_serial_port_controller.sv
// Self-checking bench for serial_port_controller: a frame-level timeline model
// predicts every output per cycle, with a few hand-computed literal checks on top.
module tb_serial_port_controller;

  localparam int NCYC = 112;

  logic       clk = 1'b0;
  logic       rst;
  logic       serIn;
  logic       serOut;
  logic       outputValid;
  logic [3:0] portEn;
  logic [1:0] port;
  logic       done;
  logic       busy;

  logic       stimSer   [NCYC];
  logic       stimRst   [NCYC];
  logic       expBusy   [NCYC];
  logic       expDone   [NCYC];
  logic       expValid  [NCYC];
  logic       expSer    [NCYC];
  logic [3:0] expPortEn [NCYC];
  logic [1:0] expPort   [NCYC];

  int total = 0;
  int bad   = 0;
  int curEdge = 0;
  bit checkOn = 1'b0;

  serial_port_controller dut (
    .clk         (clk),
    .rst         (rst),
    .serIn       (serIn),
    .serOut      (serOut),
    .outputValid (outputValid),
    .portEn      (portEn),
    .port        (port),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s edge=%0d actual=%0h required=%0h", name, curEdge, act, exp);
    end
  endtask

  // Plans one frame whose start bit is sampled at edge k. Expectations are indexed by the
  // edge after which the output is observed; rstAt >= 0 aborts the frame with reset at that edge.
  task automatic applyStimulus(input int k, input logic [1:0] p, input logic [3:0] l,
                               input logic [14:0] data, input int rstAt);
    int last;
    last = k + 6 + int'(l);
    stimSer[k]   = 1'b1;
    stimSer[k+1] = p[1];
    stimSer[k+2] = p[0];
    for (int i = 0; i < 4; i++) stimSer[k+3+i] = l[3-i];
    for (int i = 0; i < int'(l); i++) stimSer[k+7+i] = data[i];
    for (int e = k; e <= last; e++) expBusy[e] = 1'b1;
    expDone[last] = 1'b1;
    for (int i = 0; i < int'(l); i++) begin
      expValid[k+7+i]  = 1'b1;
      expSer[k+7+i]    = data[i];
      expPortEn[k+7+i] = 4'b0001 << p;
    end
    for (int e = k + 2; e < NCYC; e++) expPort[e] = p;
    if (rstAt >= 0) begin
      stimRst[rstAt] = 1'b1;
      for (int e = rstAt; e <= last; e++) begin
        stimSer[e]   = 1'b0;
        expBusy[e]   = 1'b0;
        expDone[e]   = 1'b0;
        expValid[e]  = 1'b0;
        expSer[e]    = 1'b0;
        expPortEn[e] = 4'b0000;
      end
      for (int e = rstAt; e < NCYC; e++) expPort[e] = 2'd0;
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("busy",        32'(busy),        32'(expBusy[curEdge]));
      checkOutput("done",        32'(done),        32'(expDone[curEdge]));
      checkOutput("outputValid", 32'(outputValid), 32'(expValid[curEdge]));
      checkOutput("serOut",      32'(serOut),      32'(expSer[curEdge]));
      checkOutput("portEn",      32'(portEn),      32'(expPortEn[curEdge]));
      checkOutput("port",        32'(port),        32'(expPort[curEdge]));
    end
  end

  initial begin
    rst   = 1'b1;
    serIn = 1'b0;
    for (int e = 0; e < NCYC; e++) begin
      stimSer[e] = 1'b0;  stimRst[e] = 1'b0;
      expBusy[e] = 1'b0;  expDone[e] = 1'b0;
      expValid[e] = 1'b0; expSer[e]  = 1'b0;
      expPortEn[e] = 4'b0000; expPort[e] = 2'd0;
    end
    stimRst[0] = 1'b1; stimSer[0] = 1'b1;
    stimRst[1] = 1'b1; stimSer[1] = 1'b1;
    applyStimulus(5,  2'd2, 4'd3,  15'b101,             -1);
    applyStimulus(20, 2'd3, 4'd0,  15'b0,               -1);
    applyStimulus(30, 2'd0, 4'd15, 15'b111111111111111, -1);
    applyStimulus(53, 2'd1, 4'd2,  15'b10,              -1);
    applyStimulus(66, 2'd1, 4'd4,  15'b1111,            75);
    applyStimulus(80, 2'd2, 4'd1,  15'b1,               -1);
    applyStimulus(92, 2'd0, 4'd0,  15'b0,               -1);
    stimSer[99] = 1'b1;

    checkOn = 1'b1;
    for (int e = 0; e < NCYC; e++) begin
      rst   = stimRst[e];
      serIn = stimSer[e];
      @(posedge clk);
      curEdge = e;
      @(negedge clk);
      case (e)
        0: begin
          checkOutput("rstBusy",   32'(busy),        32'd0);
          checkOutput("rstValid",  32'(outputValid), 32'd0);
          checkOutput("rstPortEn", 32'(portEn),      32'd0);
          checkOutput("rstDone",   32'(done),        32'd0);
        end
        4:  checkOutput("idleAfterRst", 32'(busy), 32'd0);
        12: begin
          checkOutput("basicSer0",   32'(serOut), 32'd1);
          checkOutput("basicPortEn", 32'(portEn), 32'h4);
          checkOutput("basicPort",   32'(port),   32'd2);
        end
        13: checkOutput("basicSer1", 32'(serOut), 32'd0);
        14: begin
          checkOutput("basicSer2", 32'(serOut), 32'd1);
          checkOutput("basicDone", 32'(done),   32'd1);
        end
        15: checkOutput("basicBusyDrop", 32'(busy), 32'd0);
        26: begin
          checkOutput("zeroDone",  32'(done),        32'd1);
          checkOutput("zeroPort",  32'(port),        32'd3);
          checkOutput("zeroValid", 32'(outputValid), 32'd0);
        end
        37: checkOutput("maxPortEn", 32'(portEn), 32'h1);
        51: begin
          checkOutput("maxDone",  32'(done),        32'd1);
          checkOutput("maxValid", 32'(outputValid), 32'd1);
        end
        53: checkOutput("backToBackStart", 32'(busy), 32'd1);
        75: begin
          checkOutput("midRstBusy",  32'(busy),        32'd0);
          checkOutput("midRstValid", 32'(outputValid), 32'd0);
        end
        80:  checkOutput("freshStart",   32'(busy), 32'd1);
        100: checkOutput("doneStartIgn", 32'(busy), 32'd0);
        default: ;
      endcase
    end
    checkOn = 1'b0;
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_port_controller.md
# serial_port_controller

Frame-sequencing controller for the serial input path. It watches the single-bit serial line, detects a frame start, and captures a port address and a payload length. It then steers the payload bits to the addressed output port with a registered data/valid pair, and pulses `done` at frame end. It sits between the raw `serIn` line and the per-port consumers, and replaces ad-hoc decode inside the main circuit.

## Interface
- `PORT_W`, 2: port-address width; number of ports = 2**PORT_W.
- `LEN_W`, 4: payload-length field width; maximum payload is 2**LEN_W-1 bits.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `serIn`  in  1  serial line, sampled every rising edge; idle level 0.
- `serOut`  out  1  registered payload bit.
- `outputValid`  out  1  high when `serOut` carries a payload bit.
- `portEn`  out  2**PORT_W  one-hot of the captured port; nonzero only while `outputValid`.
- `port`  out  PORT_W  captured port address; held from end of the port field until the next frame's port field.
- `done`  out  1  one-cycle end-of-frame pulse.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Frame on `serIn`, MSB first: start bit = 1, then PORT_W port bits, then LEN_W length bits L, then L payload bits.
- States: IDLE, PORT, LEN, DATA, DONE.
- IDLE: if `serIn`=1, go to PORT and load the bit counter with PORT_W-1. Otherwise stay in IDLE.
- PORT: shift `serIn` into the port register. When the counter reaches 0, go to LEN and load LEN_W-1. Otherwise decrement.
- LEN: shift `serIn` into the length register. On the last bit, go to DATA with counter = L-1 if L≠0. If L=0, go to DONE.
- DATA: register `serIn` into `serOut` and set `outputValid`=1. When the counter reaches 0, go to DONE. Otherwise decrement.
- DONE: `done`=1 and `serIn` is ignored. Unconditionally return to IDLE.
- Counter width is max(PORT_W, LEN_W). The counter is only decremented when nonzero, so it never wraps.
- `portEn` = (1 << `port`) gated by `outputValid`.
- Reset values: state IDLE; `serOut`, `outputValid`, `portEn`, `done`, `busy` all 0; `port` 0; length register 0; counter 0.
- `rst` overrides everything, including mid-frame. The partial frame is discarded, with no `done` and no further valid bits. `serIn` in the same cycle as `rst` is not a start bit.

## Timing
- Let cycle k be the edge at which the start bit is sampled in IDLE.
- Port bits are sampled at k+1 .. k+PORT_W.
- Length bits are sampled at k+PORT_W+1 .. k+PORT_W+LEN_W. With defaults this is k+3 .. k+6.
- Payload bit i (0-based) is sampled at k+7+i. It appears on `serOut`/`outputValid` during cycle k+8+i, a latency of 1 cycle.
- For L≥1, `done` is high during cycle k+7+L, coincident with the last `outputValid`.
- For L=0, `done` is high during cycle k+7 and `outputValid` never rises.
- The earliest next start bit is sampled at k+8+L, the first IDLE cycle. A 1 on `serIn` during DONE is not a start.
- `port` updates on the edge after the last port bit and is stable for the whole DATA phase.

## Structure
- Shared package `serial_ctrl_pkg` holds:
  - the state encoding (IDLE, PORT, LEN, DATA, DONE);
  - default PORT_W/LEN_W constants;
  - a counter-width helper.
- Sub-module `frame_bit_counter` is a loadable down-counter with `ld`, `en`, `ldVal`, `zero` and synchronous `rst`. The FSM, shift registers and output registers stay in `serial_port_controller`.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with `serIn`=1. Required: all outputs 0 and `busy`=0. After `rst` drops with `serIn`=0, the block stays in IDLE.
- **Basic frame:** start, port 10, length 0011, data 1,0,1. Required:
  - `outputValid`=1 at k+8..k+10;
  - `serOut`=1,0,1;
  - `portEn`=0100 and `port`=2;
  - `done` only at k+10;
  - `busy` drops at k+11.
- **Zero length:** start, port 11, length 0000. Required: `done` at k+7, `outputValid` never high, `port`=3.
- **Max length and back-to-back frames:** port 00, L=15, all-ones payload. Required: 15 consecutive valid cycles with `portEn`=0001 and `done` at k+22. A second start sampled at k+23 is accepted.
- **Mid-frame reset:** `rst` asserted at k+9 during the DATA phase of a 4-bit payload. Required: `outputValid`/`done`/`busy` are 0 from the next edge and no `done` is produced. The next `serIn`=1 after reset starts a fresh frame.
- **DONE-cycle start ignored:** `serIn`=1 only during the DONE cycle. Required: the block returns to IDLE and stays there with `busy`=0.
